// File: rtl/jk_pkg.sv
// Shared types and JK operation encodings for the JK bank driver.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // {j,k} ordering matches the jk_ff instances in the driven bank.
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Per-bit excitation: unchanged bits always hold, changing bits set/reset or toggle.
    function automatic logic [1:0] jk_op(input logic q, input logic t, input logic use_toggle);
        logic [1:0] op;
        if (q == t) begin
            op = JK_HOLD;
        end else if (use_toggle) begin
            op = JK_TGL;
        end else if (t) begin
            op = JK_SET;
        end else begin
            op = JK_RST;
        end
        return op;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational excitation: maps observed Q and target T to per-bit J/K.
module jk_excite
    import jk_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit USE_TOGGLE = 1'b0
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign {j[i], k[i]} = jk_op(q[i], t[i], USE_TOGGLE);
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Loads an external bank of JK flops to a requested word, verifies and retries.
//
// state | meaning
// IDLE  | j=k=0, ready for a target; accept loads first excitation
// DRIVE | j/k presented for one cycle; bank updates on the exiting edge
// CHECK | compare q_fb to target: done, re-drive, or error
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_RETRY  = 3,
    parameter bit USE_TOGGLE = 1'b0,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask,
    output logic [RW-1:0]    retry_cnt
);

    localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic             done_q, done_d, err_q, err_d;
    logic [WIDTH-1:0] err_mask_q, err_mask_d;
    logic [RW-1:0]    retry_q, retry_d;

    logic [WIDTH-1:0] ex_t, ex_j, ex_k;

    // In IDLE the excitation targets the incoming word, otherwise the captured one.
    assign ex_t = (state_q == IDLE) ? tgt_data : tgt_q;

    jk_excite #(
        .WIDTH      (WIDTH),
        .USE_TOGGLE (USE_TOGGLE)
    ) u_excite (
        .q (q_fb),
        .t (ex_t),
        .j (ex_j),
        .k (ex_k)
    );

    // Next-state and next-output logic; j/k default to hold so the bank only moves in DRIVE.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        j_d        = '0;
        k_d        = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_mask_d = err_mask_q;
        retry_d    = retry_q;
        case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d      = tgt_data;
                    retry_d    = '0;
                    err_mask_d = '0;
                    j_d        = ex_j;
                    k_d        = ex_k;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (q_fb == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_q < MAX_R) begin
                    retry_d = retry_q + 1'b1;
                    j_d     = ex_j;
                    k_d     = ex_k;
                    state_d = DRIVE;
                end else begin
                    err_d      = 1'b1;
                    err_mask_d = q_fb ^ tgt_q;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops j/k at once so the bank holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            j_q        <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_mask_q <= '0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            j_q        <= j_d;
            k_q        <= k_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_mask_q <= err_mask_d;
            retry_q    <= retry_d;
        end
    end

    assign tgt_ready = (state_q == IDLE);
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_mask  = err_mask_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench: two drivers (set/reset and toggle mode) each loading a modelled JK bank.
module tb_jk_bank_driver;

    logic       clk;
    logic       rst;
    logic       tgt_valid;
    logic [7:0] tgt_data;

    logic       ready_s, ready_t, done_s, done_t, err_s, err_t;
    logic [7:0] j_s, k_s, j_t, k_t, em_s, em_t;
    logic [1:0] rc_s, rc_t;
    logic [7:0] q_s, q_t;

    logic       pre_en;
    logic [7:0] pre_val, pre_mask;
    logic [3:0] pre_n;
    logic [7:0] stuck_mask;
    logic [3:0] left_s, left_t;

    int n_cmp = 0;
    int n_bad = 0;

    jk_bank_driver #(.WIDTH(8), .MAX_RETRY(3), .USE_TOGGLE(1'b0)) dut_s (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
        .tgt_ready(ready_s), .j(j_s), .k(k_s), .q_fb(q_s),
        .done(done_s), .err(err_s), .err_mask(em_s), .retry_cnt(rc_s)
    );

    jk_bank_driver #(.WIDTH(8), .MAX_RETRY(3), .USE_TOGGLE(1'b1)) dut_t (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
        .tgt_ready(ready_t), .j(j_t), .k(k_t), .q_fb(q_t),
        .done(done_t), .err(err_t), .err_mask(em_t), .retry_cnt(rc_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] jk_next(input logic [7:0] q, input logic [7:0] j, input logic [7:0] k);
        return (j & ~q) | (~k & q);
    endfunction

    // Bank model: preload port, plus stuck-at-0 bits for a limited number of non-hold updates.
    always @(posedge clk) begin
        if (pre_en) begin
            q_s <= pre_val;
            q_t <= pre_val;
            stuck_mask <= pre_mask;
            left_s <= pre_n;
            left_t <= pre_n;
        end else begin
            if ((j_s | k_s) != 8'h00) begin
                q_s <= jk_next(q_s, j_s, k_s) & ~((left_s != 0) ? stuck_mask : 8'h00);
                if (left_s != 0) left_s <= left_s - 4'd1;
            end
            if ((j_t | k_t) != 8'h00) begin
                q_t <= jk_next(q_t, j_t, k_t) & ~((left_t != 0) ? stuck_mask : 8'h00);
                if (left_t != 0) left_t <= left_t - 4'd1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] v, input logic [7:0] m, input logic [3:0] n);
        pre_val  = v;
        pre_mask = m;
        pre_n    = n;
        pre_en   = 1'b1;
        step();
        pre_en   = 1'b0;
    endtask

    task automatic accept(input logic [7:0] t);
        tgt_data  = t;
        tgt_valid = 1'b1;
        step();
        tgt_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0] q;
        logic [7:0] t;
        logic [7:0] js;
        logic [7:0] ks;
        logic [7:0] jt;
        logic [7:0] kt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{q:8'h0F, t:8'hF0, js:8'hF0, ks:8'h0F, jt:8'hFF, kt:8'hFF};
        vecs[1] = '{q:8'h3C, t:8'h5A, js:8'h42, ks:8'h24, jt:8'h66, kt:8'h66};
        vecs[2] = '{q:8'hA5, t:8'hA5, js:8'h00, ks:8'h00, jt:8'h00, kt:8'h00};
        vecs[3] = '{q:8'h00, t:8'hFF, js:8'hFF, ks:8'h00, jt:8'hFF, kt:8'hFF};
        vecs[4] = '{q:8'hFF, t:8'h00, js:8'h00, ks:8'hFF, jt:8'hFF, kt:8'hFF};
        vecs[5] = '{q:8'h96, t:8'h69, js:8'h69, ks:8'h96, jt:8'hFF, kt:8'hFF};
        vecs[6] = '{q:8'h12, t:8'h34, js:8'h24, ks:8'h02, jt:8'h26, kt:8'h26};

        rst = 1'b0; tgt_valid = 1'b0; tgt_data = 8'h00;
        pre_en = 1'b0; pre_val = 8'h00; pre_mask = 8'h00; pre_n = 4'd0;

        // Reset with bank at 0x00
        preload(8'h00, 8'h00, 4'd0);
        step();
        chk("rst_j_s", j_s, 8'h00);   chk("rst_k_s", k_s, 8'h00);
        chk("rst_j_t", j_t, 8'h00);   chk("rst_k_t", k_t, 8'h00);
        chk("rst_done", done_s, 1'b0); chk("rst_err", err_s, 1'b0);
        chk("rst_em", em_s, 8'h00);   chk("rst_rc", rc_s, 2'd0);
        rst = 1'b1;
        step();
        chk("rst_ready_s", ready_s, 1'b1);
        chk("rst_ready_t", ready_t, 1'b1);
        chk("idle_done", done_s, 1'b0);

        // Table of single-pass loads
        for (int i = 0; i < 7; i++) begin
            preload(vecs[i].q, 8'h00, 4'd0);
            accept(vecs[i].t);
            chk($sformatf("v%0d_c1_j_s", i), j_s, vecs[i].js);
            chk($sformatf("v%0d_c1_k_s", i), k_s, vecs[i].ks);
            chk($sformatf("v%0d_c1_j_t", i), j_t, vecs[i].jt);
            chk($sformatf("v%0d_c1_k_t", i), k_t, vecs[i].kt);
            chk($sformatf("v%0d_c1_ready", i), ready_s, 1'b0);
            step();
            chk($sformatf("v%0d_c2_q_s", i), q_s, vecs[i].t);
            chk($sformatf("v%0d_c2_q_t", i), q_t, vecs[i].t);
            chk($sformatf("v%0d_c2_j_s", i), j_s, 8'h00);
            chk($sformatf("v%0d_c2_done", i), done_s, 1'b0);
            step();
            chk($sformatf("v%0d_c3_done_s", i), done_s, 1'b1);
            chk($sformatf("v%0d_c3_done_t", i), done_t, 1'b1);
            chk($sformatf("v%0d_c3_err", i), err_s | err_t, 1'b0);
            chk($sformatf("v%0d_c3_rc", i), rc_s, 2'd0);
            chk($sformatf("v%0d_c3_ready", i), ready_s & ready_t, 1'b1);
            step();
            chk($sformatf("v%0d_c4_done", i), done_s | done_t, 1'b0);
        end

        // Back-to-back accept in the done cycle
        preload(8'h00, 8'h00, 4'd0);
        accept(8'h3C);
        step(); step();
        chk("b2b_done1", done_s, 1'b1);
        accept(8'hC3);
        chk("b2b_done_drop", done_s, 1'b0);
        chk("b2b_j_s", j_s, 8'hC3); chk("b2b_k_s", k_s, 8'h3C);
        chk("b2b_j_t", j_t, 8'hFF); chk("b2b_k_t", k_t, 8'hFF);
        step(); step();
        chk("b2b_done2", done_s & done_t, 1'b1);
        chk("b2b_q_s", q_s, 8'hC3);

        // Valid while busy must be ignored
        preload(8'h00, 8'h00, 4'd0);
        accept(8'h55);
        tgt_data = 8'hFF; tgt_valid = 1'b1;
        step();
        chk("busy_c2_j_s", j_s, 8'h00);
        step();
        tgt_valid = 1'b0;
        chk("busy_done", done_s, 1'b1);
        chk("busy_q_s", q_s, 8'h55);
        step();
        chk("busy_no_accept", ready_s, 1'b1);

        // Retry then success: bit0 stuck at 0 for the first update
        preload(8'h00, 8'h01, 4'd1);
        accept(8'h01);
        chk("rty_c1_j_s", j_s, 8'h01); chk("rty_c1_k_s", k_s, 8'h00);
        chk("rty_c1_j_t", j_t, 8'h01); chk("rty_c1_k_t", k_t, 8'h01);
        step();
        chk("rty_c2_q_s", q_s, 8'h00);
        chk("rty_c2_done", done_s, 1'b0);
        step();
        chk("rty_c3_rc_s", rc_s, 2'd1); chk("rty_c3_rc_t", rc_t, 2'd1);
        chk("rty_c3_j_s", j_s, 8'h01);  chk("rty_c3_j_t", j_t, 8'h01);
        chk("rty_c3_k_t", k_t, 8'h01);
        chk("rty_c3_done", done_s, 1'b0);
        step();
        chk("rty_c4_q_s", q_s, 8'h01);
        chk("rty_c4_done", done_s, 1'b0);
        step();
        chk("rty_c5_done_s", done_s, 1'b1); chk("rty_c5_done_t", done_t, 1'b1);
        chk("rty_c5_err", err_s | err_t, 1'b0);
        chk("rty_c5_rc", rc_s, 2'd1);

        // Exhausted retries: bit7 stuck at 0 for all four drives
        preload(8'h00, 8'h80, 4'd4);
        accept(8'h80);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("exh_c%0d_done", c), done_s | done_t, 1'b0);
            chk($sformatf("exh_c%0d_err", c), err_s | err_t, 1'b0);
            chk($sformatf("exh_c%0d_j_s", c), j_s, (c % 2 == 1) ? 8'h80 : 8'h00);
            step();
        end
        chk("exh_c9_err_s", err_s, 1'b1); chk("exh_c9_err_t", err_t, 1'b1);
        chk("exh_c9_done", done_s | done_t, 1'b0);
        chk("exh_c9_em_s", em_s, 8'h80);  chk("exh_c9_em_t", em_t, 8'h80);
        chk("exh_c9_rc_s", rc_s, 2'd3);   chk("exh_c9_rc_t", rc_t, 2'd3);
        chk("exh_c9_ready", ready_s, 1'b1);
        step();
        chk("exh_c10_err", err_s, 1'b0);
        chk("exh_c10_em_held", em_s, 8'h80);
        accept(8'h00);
        chk("exh_em_clear", em_s, 8'h00);
        chk("exh_rc_clear", rc_s, 2'd0);
        step(); step();
        chk("exh_next_done", done_s, 1'b1);

        // Reset in the middle of DRIVE
        preload(8'h00, 8'h00, 4'd0);
        accept(8'h0F);
        chk("mid_c1_j_s", j_s, 8'h0F);
        rst = 1'b0;
        #1;
        chk("mid_j_s", j_s, 8'h00); chk("mid_k_s", k_s, 8'h00);
        chk("mid_j_t", j_t, 8'h00); chk("mid_k_t", k_t, 8'h00);
        step();
        chk("mid_q_held", q_s, 8'h00);
        chk("mid_no_done", done_s | err_s | done_t | err_t, 1'b0);
        rst = 1'b1;
        step();
        chk("mid_ready", ready_s & ready_t, 1'b1);
        chk("mid_still_quiet", done_s | err_s, 1'b0);
        accept(8'hAA);
        chk("mid_new_j_s", j_s, 8'hAA); chk("mid_new_k_s", k_s, 8'h00);
        chk("mid_new_j_t", j_t, 8'hAA); chk("mid_new_k_t", k_t, 8'hAA);
        step(); step();
        chk("mid_new_done", done_s & done_t, 1'b1);
        chk("mid_new_q", q_s, 8'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
